uart_tx_param: RTL and testbench
================================

Name: uart_tx_param

Overview:
Parametrised UART transmitter, successor to the fixed 8-bit single-stop TX.
- Generalised in data width and bit period; adds two-stop-bit mode, a ready/valid input handshake and a frame-done pulse.
- Sits between the parallel data source and the serial TX pin, alongside the existing UART RX in the full UART.

Parameters:
DATA_W, 8, number of data bits per frame (5..9)
CLKS_PER_BIT, 1, clk cycles per serial bit (>=1); 1 gives one bit per clock, matching the previous generation
FIFO_DEPTH, 4, entries in the input buffer (power of two, >=2); used only when UART_TX_FIFO_EN is defined

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
P_DATA  input  DATA_W  parallel data to send, LSB transmitted first
DATA_VALID  input  1  source has a word on P_DATA
DATA_READY  output  1  block accepts P_DATA this cycle
PAR_EN  input  1  1 = insert parity bit
PAR_TYP  input  1  0 = even parity (bit = ^data), 1 = odd parity (bit = ~^data)
STOP2  input  1  1 = two stop bits, 0 = one
TX_OUT  output  1  serial line, idle high, registered
Busy  output  1  high while a frame is on the line
FRAME_DONE  output  1  one-cycle pulse in the cycle after the last stop bit ends

Behaviour:
- Reset (asynchronous, active-low): TX_OUT=1, Busy=0, DATA_READY=0 while reset is low, FRAME_DONE=0, state=IDLE, bit counter=0, prescale counter=0.
- Reset mid-frame aborts immediately. TX_OUT returns high asynchronously. No FRAME_DONE is issued.
- States: IDLE, START, DATA, PARITY, STOP.
- Handshake: a transfer occurs on a rising edge where DATA_VALID && DATA_READY.
  - No FIFO: DATA_READY = (state==IDLE) && reset.
  - DATA_VALID without DATA_READY is ignored and never latched.
- Accept edge k (IDLE):
  - Latch P_DATA into DATA_reg.
  - Latch PAR_EN, PAR_TYP, STOP2.
  - Compute PARITY_bit from the latched data.
  - Next state START.
  - Config input changes after edge k do not affect the frame.
- START: TX_OUT=0 for CLKS_PER_BIT cycles starting at edge k+1. Busy=1 from edge k+1.
- DATA: bit counter 0..DATA_W-1. TX_OUT=DATA_reg[counter], each bit held CLKS_PER_BIT cycles. After bit DATA_W-1, go to PARITY if latched PAR_EN, else STOP.
- PARITY: TX_OUT=PARITY_bit for CLKS_PER_BIT cycles, then STOP.
- STOP: TX_OUT=1 for CLKS_PER_BIT cycles (one stop bit) or 2*CLKS_PER_BIT cycles (two stop bits), then IDLE.
- End of frame: at the edge leaving STOP, Busy falls and FRAME_DONE pulses for exactly one cycle.
- Prescale counter:
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 on every bit boundary.
  - Held at 0 in IDLE.
  - Width is clog2(CLKS_PER_BIT), minimum 1.
- Frame length (clk cycles) = CLKS_PER_BIT*(1 + DATA_W + PAR_EN + 1 + STOP2).
- Back-to-back: a word presented during STOP is accepted on the first IDLE cycle. Minimum gap is one idle-high cycle between frames.
- TX_OUT never glitches; every output is driven from a flop.

Optional Feature:
Macro UART_TX_FIFO_EN.
- Defined: FIFO_DEPTH-entry input FIFO stores {P_DATA, PAR_EN, PAR_TYP, STOP2}.
  - DATA_READY = !full.
  - FSM pops in IDLE when the FIFO is non-empty, with no idle gap: the next START begins the cycle after STOP ends.
  - Busy stays high across consecutive frames.
  - Push while full is impossible because READY=0.
  - Simultaneous push and pop when full is allowed; count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Reset empties the FIFO.
- Undefined: no FIFO; DATA_READY = IDLE as above; FIFO_DEPTH is unused.

Test Plan:
1. Reset check: reset low with DATA_VALID=1 -> TX_OUT=1, Busy=0, DATA_READY=0, FRAME_DONE=0. Release reset -> DATA_READY=1 next cycle.
2. 8-bit even-parity frame: DATA_W=8, CLKS_PER_BIT=4, P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, STOP2=0.
   - TX_OUT bits: 0, 1,0,1,0,0,1,0,1, parity 0, stop 1; each bit 4 cycles.
   - Busy high 44 cycles, then one FRAME_DONE pulse.
3. Odd parity with two stops: P_DATA=0x01, PAR_TYP=1, STOP2=1, CLKS_PER_BIT=1.
   - Parity bit=0, stop high 2 cycles, Busy high 12 cycles.
   - Toggling PAR_TYP mid-frame has no effect.
4. No parity: PAR_EN=0, P_DATA=0xFF -> after data bit 7 the stop bit follows directly; frame 10 bits.
5. Busy rejection: DATA_VALID=1 with 0x3C during a frame (no FIFO) -> word not sent, DATA_READY=0. A 0x3C held until IDLE is sent once.
6. Mid-frame reset: assert reset during DATA bit 3 -> TX_OUT=1 immediately, no FRAME_DONE. The next accepted word 0x5A is transmitted correctly.
   - With UART_TX_FIFO_EN, DEPTH=4: push 5 words back-to-back -> READY drops after 4, all 5 frames are sent contiguously, Busy is never low between them.

Source files
------------

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start, DATA_W data bits (LSB first), optional parity, one or two stop bits.
// Define UART_TX_FIFO_EN to put a FIFO_DEPTH-entry input buffer in front of the frame engine.
module uart_tx_param #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] P_DATA,
  input  logic              DATA_VALID,
  output logic              DATA_READY,
  input  logic              PAR_EN,
  input  logic              PAR_TYP,
  input  logic              STOP2,
  output logic              TX_OUT,
  output logic              Busy,
  output logic              FRAME_DONE
);

  localparam int PS_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BC_W = $clog2(DATA_W);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLKS_PER_BIT - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state;
  logic [PS_W-1:0]   prescale;
  logic [BC_W-1:0]   bit_cnt;
  logic [BC_W-1:0]   bit_nxt;
  logic [DATA_W-1:0] data_reg;
  logic              par_en_reg;
  logic              stop2_reg;
  logic              parity_bit;
  logic              tx_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              ready_reg;
  logic              bit_end;
  logic              stop_last;
  logic              frame_end;

  // Word source for the next frame: either the input port or the FIFO head
  logic              load;
  logic [DATA_W-1:0] ld_data;
  logic              ld_pe;
  logic              ld_pt;
  logic              ld_s2;

  assign bit_end   = (prescale == PS_LAST);
  assign bit_nxt   = bit_cnt + 1'b1;
  // In STOP the bit counter counts stop bits already sent
  assign stop_last = !stop2_reg || (bit_cnt != '0);
  assign frame_end = (state == STOP) && bit_end && stop_last;

`ifdef UART_TX_FIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = DATA_W + 3;
  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(FIFO_DEPTH);

  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   count_next;
  logic             push;
  logic [ENT_W-1:0] head;

  assign push       = DATA_VALID && ready_reg;
  assign load       = (count != '0) && ((state == IDLE) || frame_end);
  assign count_next = count + (PTR_W + 1)'(push) - (PTR_W + 1)'(load);
  assign head       = mem[rd_ptr];
  assign {ld_data, ld_pe, ld_pt, ld_s2} = head;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {P_DATA, PAR_EN, PAR_TYP, STOP2};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ready_reg <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (load) rd_ptr <= rd_ptr + 1'b1;
      count     <= count_next;
      ready_reg <= (count_next != FULL);
    end
  end
`else
  assign load    = DATA_VALID && ready_reg && (state == IDLE);
  assign ld_data = P_DATA;
  assign ld_pe   = PAR_EN;
  assign ld_pt   = PAR_TYP;
  assign ld_s2   = STOP2;

  // Ready is registered as "next state is IDLE" so it stays a flop output
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ready_reg <= 1'b0;
    else        ready_reg <= ((state == IDLE) && !load) || frame_end;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      prescale   <= '0;
      bit_cnt    <= '0;
      data_reg   <= '0;
      par_en_reg <= 1'b0;
      stop2_reg  <= 1'b0;
      parity_bit <= 1'b0;
      tx_reg     <= 1'b1;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= frame_end;
      if (load) begin
        data_reg   <= ld_data;
        par_en_reg <= ld_pe;
        stop2_reg  <= ld_s2;
        parity_bit <= (^ld_data) ^ ld_pt;
        state      <= START;
        prescale   <= '0;
        bit_cnt    <= '0;
        tx_reg     <= 1'b0;
        busy_reg   <= 1'b1;
      end else begin
        case (state)
          IDLE: prescale <= '0;
          START: begin
            if (!bit_end) prescale <= prescale + 1'b1;
            else begin
              prescale <= '0;
              bit_cnt  <= '0;
              state    <= DATA;
              tx_reg   <= data_reg[0];
            end
          end
          DATA: begin
            if (!bit_end) prescale <= prescale + 1'b1;
            else begin
              prescale <= '0;
              if (bit_cnt == BC_LAST) begin
                bit_cnt <= '0;
                if (par_en_reg) begin
                  state  <= PARITY;
                  tx_reg <= parity_bit;
                end else begin
                  state  <= STOP;
                  tx_reg <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_nxt;
                tx_reg  <= data_reg[bit_nxt];
              end
            end
          end
          PARITY: begin
            if (!bit_end) prescale <= prescale + 1'b1;
            else begin
              prescale <= '0;
              bit_cnt  <= '0;
              state    <= STOP;
              tx_reg   <= 1'b1;
            end
          end
          STOP: begin
            if (!bit_end) prescale <= prescale + 1'b1;
            else begin
              prescale <= '0;
              if (!stop_last) bit_cnt <= bit_nxt;
              else begin
                bit_cnt  <= '0;
                state    <= IDLE;
                busy_reg <= 1'b0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign TX_OUT     = tx_reg;
  assign Busy       = busy_reg;
  assign FRAME_DONE = done_reg;
  assign DATA_READY = ready_reg;

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: vector table, hand-written corner sequences, randomized frames vs a bit-list model.
module tb_uart_tx_param;
  localparam int DW  = 8;
  localparam int CPB = 4;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] P_DATA = '0;
  logic          DATA_VALID = 1'b0;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic          STOP2 = 1'b0;
  logic          DATA_READY;
  logic          TX_OUT;
  logic          Busy;
  logic          FRAME_DONE;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_tx_param #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
    .DATA_READY(DATA_READY), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2),
    .TX_OUT(TX_OUT), .Busy(Busy), .FRAME_DONE(FRAME_DONE)
  );

  typedef struct {
    logic [7:0]  data;
    logic        pe;
    logic        pt;
    logic        s2;
    logic [15:0] bits;   // line level per bit, bit 0 sent first
    int          len;
    string       name;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: list of line levels for one frame, built straight from the frame rules
  function automatic void model(input logic [7:0] d, input logic pe, input logic pt, input logic s2,
                                output logic [15:0] bits, output int len);
    int ones = 0;
    bits = '0;
    len = 0;
    bits[len] = 1'b0; len++;
    for (int i = 0; i < DW; i++) begin
      bits[len] = d[i]; len++;
      ones += int'(d[i]);
    end
    if (pe) begin
      bits[len] = ((ones % 2) == 1) ^ pt; len++;
    end
    bits[len] = 1'b1; len++;
    if (s2) begin
      bits[len] = 1'b1; len++;
    end
  endfunction

  // Present a word and return right after the edge from which the frame's START is on the line
  task automatic offer(input logic [7:0] d, input logic pe, input logic pt, input logic s2);
    int n = 0;
    @(negedge clk);
    while (!DATA_READY && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", DATA_READY, 1);
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; STOP2 = s2; DATA_VALID = 1'b1;
    @(posedge clk);
`ifdef UART_TX_FIFO_EN
    #1 DATA_VALID = 1'b0;
    @(posedge clk);
`endif
  endtask

  task automatic check_frame(input logic [15:0] bits, input int len, input logic done_first, input string tag);
    int bad_tx = 0, bad_busy = 0, bad_done = 0, bad_rdy = 0;
    for (int i = 0; i < len * CPB; i++) begin
      @(negedge clk);
      if (TX_OUT !== bits[i / CPB]) bad_tx++;
      if (Busy !== 1'b1) bad_busy++;
      if (i == 0 && done_first) chk({tag, "_done_at_start"}, FRAME_DONE, 1);
      else if (FRAME_DONE !== 1'b0) bad_done++;
`ifndef UART_TX_FIFO_EN
      if (DATA_READY !== 1'b0) bad_rdy++;
`endif
    end
    chk({tag, "_tx_bits"}, bad_tx, 0);
    chk({tag, "_busy_high"}, bad_busy, 0);
    chk({tag, "_no_early_done"}, bad_done, 0);
    chk({tag, "_ready_low"}, bad_rdy, 0);
    $display("[TB] frame %s bits=%h len=%0d cycles=%0d", tag, bits, len, len * CPB);
  endtask

  task automatic end_frame(input string tag);
    @(negedge clk);
    chk({tag, "_done_pulse"}, FRAME_DONE, 1);
    chk({tag, "_busy_fall"}, Busy, 0);
    chk({tag, "_tx_idle"}, TX_OUT, 1);
  endtask

  task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic s2,
                      input logic [15:0] bits, input int len, input string tag);
    offer(d, pe, pt, s2);
    // Config and data change right after acceptance must not affect the frame
    #1 DATA_VALID = 1'b0;
    P_DATA = $urandom; PAR_EN = ~pe; PAR_TYP = ~pt; STOP2 = ~s2;
    check_frame(bits, len, 1'b0, tag);
    end_frame(tag);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, FRAME_DONE, 0);
    chk({tag, "_idle_busy"}, Busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] mb;
    int          ml;
    int          busy_seen;
    int          done_seen;

    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 16'h054A, 11, "a5_even"};
    vecs[1] = '{8'h01, 1'b1, 1'b1, 1'b1, 16'h0C02, 12, "01_odd_2stop"};
    vecs[2] = '{8'hFF, 1'b0, 1'b0, 1'b0, 16'h03FE, 10, "ff_nopar"};
    vecs[3] = '{8'h3C, 1'b1, 1'b1, 1'b1, 16'h0E78, 12, "3c_odd_2stop"};

    // Reset held low with a valid word waiting
    reset = 1'b0; DATA_VALID = 1'b1; P_DATA = 8'h55;
    repeat (3) @(negedge clk);
    chk("rst_tx", TX_OUT, 1);
    chk("rst_busy", Busy, 0);
    chk("rst_ready", DATA_READY, 0);
    chk("rst_done", FRAME_DONE, 0);
    DATA_VALID = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_release_ready", DATA_READY, 1);
    chk("rst_release_busy", Busy, 0);

    for (int v = 0; v < 4; v++)
      send(vecs[v].data, vecs[v].pe, vecs[v].pt, vecs[v].s2, vecs[v].bits, vecs[v].len, vecs[v].name);

`ifndef UART_TX_FIFO_EN
    // Word offered mid-frame is ignored, then sent once on the first idle cycle
    offer(8'hFF, 1'b0, 1'b0, 1'b0);
    #1 P_DATA = 8'h3C; PAR_EN = 1'b1; PAR_TYP = 1'b1; STOP2 = 1'b1;
    check_frame(16'h03FE, 10, 1'b0, "busy_reject_ff");
    end_frame("busy_reject_ff");
    @(posedge clk);
    #1 DATA_VALID = 1'b0;
    check_frame(16'h0E78, 12, 1'b0, "held_3c");
    end_frame("held_3c");
    busy_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (Busy !== 1'b0) busy_seen++;
    end
    chk("held_3c_sent_once", busy_seen, 0);
`endif

    // Reset during data bit 3 of 0xA5
    offer(8'hA5, 1'b1, 1'b0, 1'b0);
    #1 DATA_VALID = 1'b0;
    for (int i = 0; i < 18; i++) @(negedge clk);
    chk("midrst_tx_before", TX_OUT, 0);
    #1 reset = 1'b0;
    #1;
    chk("midrst_tx_async", TX_OUT, 1);
    chk("midrst_busy", Busy, 0);
    chk("midrst_ready", DATA_READY, 0);
    done_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (FRAME_DONE !== 1'b0) done_seen++;
    end
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (FRAME_DONE !== 1'b0) done_seen++;
    end
    chk("midrst_no_done", done_seen, 0);
    chk("midrst_ready_back", DATA_READY, 1);
    send(8'h5A, 1'b0, 1'b0, 1'b0, 16'h02B4, 10, "after_rst_5a");

    // Randomized frames against the model
    for (int r = 0; r < 24; r++) begin
      logic [7:0] d;
      logic pe, pt, s2;
      d = 8'($urandom); pe = 1'($urandom); pt = 1'($urandom); s2 = 1'($urandom);
      model(d, pe, pt, s2, mb, ml);
      send(d, pe, pt, s2, mb, ml, $sformatf("rnd%0d_%h", r, d));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

`ifdef UART_TX_FIFO_EN
    begin
      logic [15:0] fb [5];
      int          fl [5];
      logic [7:0]  fd [5];
      logic        fs [5];
      for (int w = 0; w < 5; w++) begin
        fd[w] = 8'($urandom);
        fs[w] = w[0];
        model(fd[w], 1'b1, 1'b0, fs[w], fb[w], fl[w]);
      end
      @(negedge clk);
      fork
        begin
          for (int w = 0; w < 5; w++) begin
            P_DATA = fd[w]; PAR_EN = 1'b1; PAR_TYP = 1'b0; STOP2 = fs[w]; DATA_VALID = 1'b1;
            @(posedge clk);
            #1;
          end
          DATA_VALID = 1'b0;
          chk("fifo_full_ready", DATA_READY, 0);
        end
        begin
          @(posedge clk);
          @(posedge clk);
          for (int w = 0; w < 5; w++)
            check_frame(fb[w], fl[w], w != 0, $sformatf("fifo%0d", w));
          end_frame("fifo_last");
        end
      join
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
